// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter states and character-length helpers.
package uart_pkg;

    localparam int unsigned MIN_BITS           = 5;
    localparam int unsigned DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [1:0] {
        EVEN  = 2'b00,
        ODD   = 2'b01,
        MARK  = 2'b10,
        SPACE = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4,
        TX_BREAK  = 3'd5
    } tx_state_e;

    // Limit a requested character length to MIN_BITS..max_bits.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned max_bits);
        if (len < 4'(MIN_BITS)) begin
            return 4'(MIN_BITS);
        end else if (32'(len) > max_bits) begin
            return 4'(max_bits);
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy flags and a sticky overflow indicator.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_d;
    logic             push_c;
    logic             pop_c;

    // Full is the registered flag, so a same-cycle pop never makes room for a write.
    assign push_c    = wr_en && !full;
    assign pop_c     = rd_en && !empty;
    assign rd_data_c = mem[rd_ptr];

    // Next occupancy from push/pop.
    always_comb begin
        level_d = level;
        case ({push_c, pop_c})
            2'b10:   level_d = level + LW'(1);
            2'b01:   level_d = level - LW'(1);
            default: level_d = level;
        endcase
    end

    // Pointers, occupancy flags and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            level    <= level_d;
            full     <= (level_d == LW'(DEPTH));
            empty    <= (level_d == '0);
            overflow <= overflow || (wr_en && full);
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO-fed framing with parity, 1/2 stop bits, CTS gating and break.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int unsigned MAX_BITS   = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick_i,
    input  logic                          wr_en_i,
    input  logic [MAX_BITS-1:0]           wr_data_i,
    input  logic [3:0]                    data_len_i,
    input  logic                          parity_en_i,
    input  logic [1:0]                    parity_mode_i,
    input  logic                          stop2_i,
    input  logic                          break_i,
    input  logic                          cts_n_i,
    output logic                          tx_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = TX_IDLE;
    localparam logic [2:0] S_START  = TX_START;
    localparam logic [2:0] S_DATA   = TX_DATA;
    localparam logic [2:0] S_PARITY = TX_PARITY;
    localparam logic [2:0] S_STOP   = TX_STOP;
    localparam logic [2:0] S_BREAK  = TX_BREAK;

    logic [2:0]          state_q,    state_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]          bit_cnt_q,  bit_cnt_d;
    logic [MAX_BITS-1:0] shreg_q,    shreg_d;
    logic [3:0]          len_q,      len_d;
    logic                par_en_q,   par_en_d;
    logic                par_bit_q,  par_bit_d;
    logic                stop2_q,    stop2_d;
    logic                from_brk_q, from_brk_d;
    logic                tx_d;
    logic                done_d;

    logic                pop_c;
    logic [MAX_BITS-1:0] fifo_data_c;
    logic [3:0]          len_c;
    logic                par_even_c;
    logic                par_bit_c;
    logic [3:0]          frame_bits_c;
    logic                bit_end_c;
    logic                brk_done_c;

    uart_sync_fifo #(
        .WIDTH (MAX_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_i),
        .wr_data   (wr_data_i),
        .rd_en     (pop_c),
        .rd_data_c (fifo_data_c),
        .full      (full_o),
        .empty     (empty_o),
        .level     (level_o),
        .overflow  (overflow_o)
    );

    // Parity bit of the head character under the live configuration, latched at pop.
    always_comb begin
        len_c      = clamp_len(data_len_i, MAX_BITS);
        par_even_c = 1'b0;
        for (int i = 0; i < MAX_BITS; i++) begin
            if (4'(i) < len_c) par_even_c = par_even_c ^ fifo_data_c[i];
        end
        case (parity_mode_e'(parity_mode_i))
            EVEN:    par_bit_c = par_even_c;
            ODD:     par_bit_c = !par_even_c;
            MARK:    par_bit_c = 1'b1;
            SPACE:   par_bit_c = 1'b0;
            default: par_bit_c = 1'b0;
        endcase
    end

    // Bit-boundary and break-minimum conditions from the latched frame.
    always_comb begin
        bit_end_c    = tick_i && (tick_cnt_q == TICK_LAST);
        frame_bits_c = 4'd2 + len_q + 4'(par_en_q) + 4'(stop2_q);
        brk_done_c   = (bit_cnt_q == frame_bits_c) ||
                       (bit_end_c && (bit_cnt_q == frame_bits_c - 4'd1));
    end

    // Next-state and line-level logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        len_d      = len_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        from_brk_d = from_brk_q;
        tx_d       = tx_o;
        done_d     = 1'b0;
        pop_c      = 1'b0;

        if ((state_q != S_IDLE) && tick_i) begin
            tick_cnt_d = bit_end_c ? '0 : tick_cnt_q + TW'(1);
        end

        case (state_q)
            S_IDLE: begin
                tx_d       = 1'b1;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (tick_i) begin
                    if (break_i) begin
                        state_d    = S_BREAK;
                        tx_d       = 1'b0;
                        len_d      = len_c;
                        par_en_d   = parity_en_i;
                        stop2_d    = stop2_i;
                        from_brk_d = 1'b1;
                    end else if (!empty_o && !cts_n_i) begin
                        state_d    = S_START;
                        tx_d       = 1'b0;
                        pop_c      = 1'b1;
                        shreg_d    = fifo_data_c;
                        len_d      = len_c;
                        par_en_d   = parity_en_i;
                        par_bit_d  = par_bit_c;
                        stop2_d    = stop2_i;
                        from_brk_d = 1'b0;
                    end
                end
            end
            S_START: begin
                if (bit_end_c) begin
                    state_d   = S_DATA;
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end_c) begin
                    if (bit_cnt_q == len_q - 4'd1) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shreg_d   = shreg_q >> 1;
                        tx_d      = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end_c) begin
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (bit_end_c) begin
                    if (stop2_q && (bit_cnt_q == 4'd0)) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        done_d  = !from_brk_q;
                    end
                end
            end
            S_BREAK: begin
                tx_d = 1'b0;
                if (tick_i) begin
                    if (brk_done_c && !break_i) begin
                        state_d    = S_STOP;
                        tx_d       = 1'b1;
                        stop2_d    = 1'b1;
                        bit_cnt_d  = '0;
                        tick_cnt_d = '0;
                    end else if (bit_end_c && (bit_cnt_q != frame_bits_c)) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State, frame registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            len_q      <= 4'(MIN_BITS);
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            from_brk_q <= 1'b0;
            tx_o       <= 1'b1;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            len_q      <= len_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            from_brk_q <= from_brk_d;
            tx_o       <= tx_d;
            done_o     <= done_d;
            busy_o     <= (state_d != S_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Self-checking bench for uart_tx_buf: line waveform checked against a frame-level model.
module tb_uart_tx_buf;

    localparam int OS       = 16;
    localparam int DEPTH    = 4;
    localparam int MB       = 9;
    localparam int TICK_DIV = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_i;
    logic       wr_en_i;
    logic [8:0] wr_data_i;
    logic [3:0] data_len_i;
    logic       parity_en_i;
    logic [1:0] parity_mode_i;
    logic       stop2_i;
    logic       break_i;
    logic       cts_n_i;
    logic       tx_o;
    logic       full_o;
    logic       empty_o;
    logic [2:0] level_o;
    logic       overflow_o;
    logic       busy_o;
    logic       done_o;

    uart_tx_buf #(
        .FIFO_DEPTH (DEPTH),
        .OVERSAMPLE (OS),
        .MAX_BITS   (MB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick_i        (tick_i),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .data_len_i    (data_len_i),
        .parity_en_i   (parity_en_i),
        .parity_mode_i (parity_mode_i),
        .stop2_i       (stop2_i),
        .break_i       (break_i),
        .cts_n_i       (cts_n_i),
        .tx_o          (tx_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .level_o       (level_o),
        .overflow_o    (overflow_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected line content of one frame, one entry per bit time.
    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          done;
    } frame_t;

    frame_t exp_q[$];
    int     gap_log[$];

    function automatic int clamp(input int len_raw);
        return (len_raw < 5) ? 5 : ((len_raw > MB) ? MB : len_raw);
    endfunction

    function automatic frame_t make_frame(input int ch, input int len_raw, input bit pen,
                                          input int mode, input bit s2);
        frame_t f;
        int len  = clamp(len_raw);
        int ones = 0;
        int k    = 0;
        f.bits = '0;
        f.bits[k] = 1'b0; k++;
        for (int i = 0; i < len; i++) begin
            f.bits[k] = 1'((ch >> i) & 1);
            ones += (ch >> i) & 1;
            k++;
        end
        if (pen) begin
            case (mode)
                0:       f.bits[k] = 1'(ones % 2);
                1:       f.bits[k] = 1'(1 - (ones % 2));
                2:       f.bits[k] = 1'b1;
                default: f.bits[k] = 1'b0;
            endcase
            k++;
        end
        f.bits[k] = 1'b1; k++;
        if (s2) begin
            f.bits[k] = 1'b1; k++;
        end
        f.n    = k;
        f.done = 1'b1;
        return f;
    endfunction

    function automatic frame_t make_break(input int len_raw, input bit pen, input bit s2);
        frame_t f;
        int low = 2 + clamp(len_raw) + int'(pen) + int'(s2);
        f.bits = '0;
        f.bits[low]     = 1'b1;
        f.bits[low + 1] = 1'b1;
        f.n    = low + 2;
        f.done = 1'b0;
        return f;
    endfunction

    // Line monitor: aligns on the first low tick sample and compares each bit time.
    bit     mon_in_frame = 1'b0;
    bit     mon_pend     = 1'b0;
    bit     mon_pend_done;
    frame_t mon_f;
    int     mon_bit, mon_sub, mon_ones;
    int     mon_gap   = 0;
    int     done_cnt  = 0;
    int     level_max = 0;

    always @(negedge clk) begin
        if (rst) begin
            mon_in_frame = 1'b0;
            mon_pend     = 1'b0;
            mon_gap      = 0;
        end else begin
            if (done_o) done_cnt++;
            if (int'(level_o) > level_max) level_max = int'(level_o);
            if (mon_pend) begin
                check("done_at_frame_end", int'(done_o), int'(mon_pend_done));
                mon_pend = 1'b0;
            end
            if (tick_i) begin
                if (!mon_in_frame) begin
                    if (tx_o == 1'b0) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_start_bit", int'(tx_o), 1);
                        end else begin
                            mon_f        = exp_q.pop_front();
                            mon_in_frame = 1'b1;
                            mon_bit      = 0;
                            mon_sub      = 0;
                            mon_ones     = 0;
                            gap_log.push_back(mon_gap);
                        end
                    end else begin
                        mon_gap++;
                    end
                end
                if (mon_in_frame) begin
                    mon_ones += int'(tx_o);
                    mon_sub++;
                    if (mon_sub == OS) begin
                        check($sformatf("line_bit%0d_high_ticks", mon_bit), mon_ones,
                              mon_f.bits[mon_bit] ? OS : 0);
                        mon_bit++;
                        mon_sub  = 0;
                        mon_ones = 0;
                        if (mon_bit == mon_f.n) begin
                            mon_in_frame  = 1'b0;
                            mon_pend      = 1'b1;
                            mon_pend_done = mon_f.done;
                            mon_gap       = 0;
                        end
                    end
                end
            end
        end
    end

    // Oversample strobe: one clk wide, every TICK_DIV clocks.
    initial begin
        int tdiv = 0;
        tick_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tick_i = (tdiv == 0);
            tdiv   = (tdiv + 1) % TICK_DIV;
        end
    end

    task automatic set_cfg(input int len, input int pen, input int mode, input int s2);
        data_len_i    = 4'(len);
        parity_en_i   = 1'(pen);
        parity_mode_i = 2'(mode);
        stop2_i       = 1'(s2);
    endtask

    task automatic push(input int ch, input bit expect_frame);
        wr_en_i   = 1'b1;
        wr_data_i = 9'(ch);
        if (expect_frame)
            exp_q.push_back(make_frame(ch, int'(data_len_i), parity_en_i,
                                       int'(parity_mode_i), stop2_i));
        @(posedge clk);
        #1;
        wr_en_i = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            #2;
            if (tick_i) c++;
        end
    endtask

    task automatic wait_idle(input int limit);
        bit ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk);
            #2;
            if (empty_o && !busy_o && !mon_in_frame && !mon_pend && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_within_budget", int'(ok), 1);
    endtask

    initial begin
        int d0;
        int zeros;
        int t;
        bit started;
        int n;

        rst       = 1'b1;
        wr_en_i   = 1'b0;
        wr_data_i = '0;
        break_i   = 1'b0;
        cts_n_i   = 1'b0;
        set_cfg(8, 0, 0, 0);

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_tx", int'(tx_o), 1);
        check("rst_full", int'(full_o), 0);
        check("rst_empty", int'(empty_o), 1);
        check("rst_level", int'(level_o), 0);
        check("rst_overflow", int'(overflow_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 8N1 frame of 0xA5
        d0 = done_cnt;
        push(9'h0A5, 1'b1);
        wait_idle(20000);
        check("8n1_done_pulses", done_cnt - d0, 1);
        check("8n1_empty_after", int'(empty_o), 1);

        // Parity modes on 0x7F, 7 bits, two stop bits
        for (int m = 0; m < 4; m++) begin
            set_cfg(7, 1, m, 1);
            d0 = done_cnt;
            push(9'h07F, 1'b1);
            wait_idle(20000);
            check($sformatf("parity_mode%0d_done", m), done_cnt - d0, 1);
        end

        // Back-to-back frames and overflow
        set_cfg(8, 0, 0, 0);
        cts_n_i   = 1'b1;
        level_max = 0;
        for (int i = 0; i < 4; i++) push(9'h031 + i, 1'b1);
        check("b2b_overflow_before", int'(overflow_o), 0);
        check("b2b_full_at_4", int'(full_o), 1);
        push(9'h0EE, 1'b0);
        check("b2b_overflow_after", int'(overflow_o), 1);
        check("b2b_level_after_drop", int'(level_o), 4);
        gap_log.delete();
        d0 = done_cnt;
        cts_n_i = 1'b0;
        wait_idle(40000);
        check("b2b_level_peak", level_max, 4);
        check("b2b_done_pulses", done_cnt - d0, 4);
        check("b2b_frames_seen", gap_log.size(), 4);
        for (int i = 1; i < gap_log.size(); i++)
            check($sformatf("b2b_gap_ticks%0d", i), gap_log[i], 1);
        check("overflow_sticky", int'(overflow_o), 1);

        // CTS gating at frame boundaries only
        cts_n_i = 1'b1;
        push(9'h055, 1'b1);
        zeros = 0;
        t     = 0;
        while (t < 20 * OS) begin
            @(posedge clk);
            #2;
            if (tick_i) begin
                t++;
                if (!tx_o) zeros++;
            end
        end
        check("cts_hold_low_ticks", zeros, 0);
        check("cts_hold_level", int'(level_o), 1);
        d0      = done_cnt;
        cts_n_i = 1'b0;
        t       = 0;
        started = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #2;
            if (!tx_o) begin
                started = 1'b1;
                break;
            end
            if (tick_i) t++;
        end
        check("cts_start_within_one_tick", int'(started && t <= 1), 1);
        wait_ticks(5 * OS);
        cts_n_i = 1'b1;
        wait_idle(20000);
        check("cts_midframe_done", done_cnt - d0, 1);
        cts_n_i = 1'b0;

        // Short break in 8N1 with data queued behind it
        set_cfg(8, 0, 0, 0);
        exp_q.push_back(make_break(8, 1'b0, 1'b0));
        d0      = done_cnt;
        break_i = 1'b1;
        wait_ticks(1);
        push(9'h03C, 1'b1);
        wait_ticks(2);
        check("break_busy", int'(busy_o), 1);
        check("break_fifo_kept", int'(level_o), 1);
        break_i = 1'b0;
        wait_idle(20000);
        check("break_done_pulses", done_cnt - d0, 1);

        // Randomized frames across configurations, including clamped lengths
        for (int b = 0; b < 15; b++) begin
            set_cfg(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
            n  = int'($urandom_range(1, DEPTH));
            d0 = done_cnt;
            for (int i = 0; i < n; i++) begin
                push(int'($urandom_range(0, 511)), 1'b1);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            wait_idle(40000);
            check($sformatf("rand%0d_done_pulses", b), done_cnt - d0, n);
        end

        // Reset during DATA
        set_cfg(8, 0, 0, 0);
        for (int i = 0; i < 3; i++) push(9'h0C3 + i, 1'b1);
        started = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(posedge clk);
            #2;
            if (busy_o) begin
                started = 1'b1;
                break;
            end
        end
        check("rst_test_frame_started", int'(started), 1);
        wait_ticks(2 * OS + 4);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx", int'(tx_o), 1);
        check("midrst_busy", int'(busy_o), 0);
        check("midrst_level", int'(level_o), 0);
        check("midrst_empty", int'(empty_o), 1);
        check("midrst_overflow", int'(overflow_o), 0);
        check("midrst_done", int'(done_o), 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_ticks(12 * OS);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_line_idle", int'(tx_o), 1);
        push(9'h05A, 1'b1);
        wait_idle(20000);
        check("post_rst_done", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered, parametrised UART transmitter that replaces the single-shot transmitter in the APB-UART datapath. The APB register block pushes characters into an internal TX FIFO. The block serialises them back-to-back, with:
- per-frame data length, parity mode and stop bits;
- CTS flow control checked at frame boundaries;
- break generation.

Bit timing comes from an external oversampling tick shared with the receiver.

## Interface
- `FIFO_DEPTH`, 16, TX FIFO entries; power of two, ≥2
- `OVERSAMPLE`, 16, `tick_i` pulses per bit; ≥4
- `MAX_BITS`, 9, widest character supported; 5..9
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tick_i`  in  1  oversample strobe, one `clk` wide
- `wr_en_i`  in  1  push `wr_data_i` into the FIFO
- `wr_data_i`  in  MAX_BITS  character, LSB first on the line
- `data_len_i`  in  4  data bits per frame, 5..MAX_BITS; out-of-range values clamp to the nearest limit
- `parity_en_i`  in  1  append a parity bit
- `parity_mode_i`  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- `stop2_i`  in  1  0: one stop bit, 1: two stop bits
- `break_i`  in  1  request a line break
- `cts_n_i`  in  1  active-low clear-to-send; already synchronised
- `tx_o`  out  1  serial line; reset 1
- `full_o`  out  1  FIFO full; reset 0
- `empty_o`  out  1  FIFO empty; reset 1
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy; reset 0
- `overflow_o`  out  1  sticky: a write was attempted while full; reset 0, cleared only by `rst`
- `busy_o`  out  1  state ≠ IDLE; reset 0
- `done_o`  out  1  one-cycle pulse at the end of each character frame; reset 0

## Operation
- **FIFO.** Write when `wr_en_i && !full_o`. A write while full is dropped and sets `overflow_o`. A pop in the same cycle does not free space for that write. A write into an empty FIFO becomes poppable on the following cycle.
- **States.** IDLE, START, DATA, PARITY, STOP, BREAK.
- **IDLE, `tx_o`=1.** On a `tick_i` cycle, evaluate in priority order:
  - `break_i` → BREAK.
  - else `!empty_o && !cts_n_i` → pop the head, latch `data_len_i`/`parity_en_i`/`parity_mode_i`/`stop2_i` into frame registers, go to START.
  - else stay in IDLE.
- **START.** `tx_o`=0 for one bit → DATA.
- **DATA.** Sends bits [0..len-1] of the popped character, LSB first. Bits above len are ignored. Then → PARITY if enabled, else → STOP.
- **PARITY.**
  - Even: XOR of the len data bits.
  - Odd: inverse of even.
  - Mark: 1. Space: 0.
  - Then → STOP.
- **STOP.** `tx_o`=1 for 1 or 2 bits. At the end, pulse `done_o` (unless entered from BREAK) → IDLE. Back-to-back frames are possible: the next start bit can begin on the next `tick_i`.
- **BREAK.** `tx_o`=0 while `break_i` is held. The minimum hold is one full frame of the latched config: 1+len+parity+stop bits. On release after the minimum, go to STOP forced to 2 stop bits. No `done_o` pulse. FIFO contents are preserved.
- **CTS** is sampled only in IDLE. Deasserting it mid-frame never truncates the frame.
- Configuration inputs changing mid-frame have no effect until the next frame.
- **`rst` mid-frame:**
  - All outputs return to their reset values immediately (asynchronously); `tx_o`=1.
  - FIFO empties.
  - The frame is lost and no `done_o` pulse is issued.

## Timing
- A bit lasts exactly OVERSAMPLE `tick_i` pulses, counted by a $clog2(OVERSAMPLE)-bit counter that resets at each bit boundary.
- Frame start: the state and `tx_o` change on the `clk` edge after the `tick_i` cycle that satisfies the IDLE conditions. The pop (`level_o` decrement) happens on that same edge.
- Bit boundaries: every OVERSAMPLE-th tick after the frame start, `tx_o` updates on the edge that ends the tick cycle.
- `done_o` is high for the single `clk` after the final stop-bit tick, coincident with the return to IDLE.
- `level_o`, `full_o` and `empty_o` are registered and updated on the edge following a push or pop.
- A simultaneous push and pop leaves `level_o` unchanged.
- Frame length in ticks: OVERSAMPLE×(1+len+parity_en+1+stop2).

## Structure
- Shared package `uart_pkg`:
  - `parity_mode_e` enum (EVEN, ODD, MARK, SPACE);
  - `tx_state_e`;
  - constants `MIN_BITS=5` and `DEFAULT_OVERSAMPLE=16`.
- Sub-module `uart_sync_fifo`: parametrised width/depth, registered level/full/empty. It is reused by the receiver later.
- The FSM, bit counter, tick counter and shift register live in `uart_tx_buf`.

## Test plan
- **8N1 frame.** Push 0xA5 with len=8, no parity, 1 stop. Required: `tx_o` shows 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks. One `done_o` pulse; `empty_o` returns to 1.
- **Parity modes.** Push 0x7F with len=7, even, 2 stop. Required: parity bit 1, then two stop bits. Repeat with odd (parity 0), mark (1) and space (0).
- **Back-to-back and full.** FIFO_DEPTH=4: write 5 characters in consecutive cycles. Required: the 5th is dropped, `overflow_o`=1, `level_o` peaks at 4. Four contiguous frames with no idle bit between them; four `done_o` pulses.
- **CTS.** Set `cts_n_i`=1, push 0x55. Required: `tx_o` stays 1 for 20 bit times. Set `cts_n_i`=0: the frame starts within one tick. Raise `cts_n_i` mid-frame: the frame completes.
- **Break.** Assert `break_i` for 3 ticks in an 8N1 config. Required: `tx_o`=0 for a full 10-bit minimum, then 2 bit times of 1. No `done_o`; queued data is sent afterwards.
- **Reset mid-frame.** Assert `rst` during the DATA state. Required: `tx_o`=1, `busy_o`=0, `level_o`=0 immediately. No `done_o` pulse.
